pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage instruction words and memory handshake in, stall controls out.
interface pipe_hazard_ctrl_if;
  logic [31:0] ins_D;
  logic [31:0] ins_E;
  logic [31:0] ins_M;
  logic [4:0]  WD_ADD_E;
  logic        mem_ack;
  logic        stop_F;
  logic        stop_D;
  logic        stop_E;
  logic        stop_M;
  logic        flush_E;
  logic        mem_req;
  logic        md_busy;

  modport master (
    output ins_D, ins_E, ins_M, WD_ADD_E, mem_ack,
    input  stop_F, stop_D, stop_E, stop_M, flush_E, mem_req, md_busy
  );

  modport slave (
    input  ins_D, ins_E, ins_M, WD_ADD_E, mem_ack,
    output stop_F, stop_D, stop_E, stop_M, flush_E, mem_req, md_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use, hi/lo-after-mult/div and data-memory wait stalls for a 5-stage pipe.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);
  localparam int unsigned MD_W  = 6;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, MD_BUSY = 2'd2} state_e;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic logic is_md(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
    return (op == 6'h00) && (fn >= 6'h18) && (fn <= 6'h1B);
  endfunction

  function automatic logic is_hilo(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
    return ((op == 6'h00) && (fn >= 6'h10) && (fn <= 6'h13)) || is_md(op, fn);
  endfunction

  state_e            mem_state_q, mem_state_d;
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;

  logic [OP_W-1:0]   op_d, fn_d, op_e, fn_e, op_m;
  logic [REG_W-1:0]  rs_d, rt_d;
  logic              mem_acc_m, mem_stall, load_use, hilo_stall, md_busy_c;
  logic              unused_ins_bits;

  // Field extraction; remaining instruction bits are irrelevant to hazards.
  always_comb begin
    op_d = hz.ins_D[31:26];
    fn_d = hz.ins_D[5:0];
    rs_d = hz.ins_D[25:21];
    rt_d = hz.ins_D[20:16];
    op_e = hz.ins_E[31:26];
    fn_e = hz.ins_E[5:0];
    op_m = hz.ins_M[31:26];
    unused_ins_bits = ^{hz.ins_D[15:6], hz.ins_E[25:6], hz.ins_M[25:0]};
  end

  always_comb begin
    mem_acc_m  = is_load(op_m) || is_store(op_m);
    mem_stall  = mem_acc_m && !hz.mem_ack;
    md_busy_c  = (md_cnt_q != '0);
    hilo_stall = md_busy_c && is_hilo(op_d, fn_d);
    load_use   = is_load(op_e) && (hz.WD_ADD_E != '0) &&
                 ((hz.WD_ADD_E == rs_d) || (hz.WD_ADD_E == rt_d));
  end

  // Stall outputs: a memory wait freezes the whole pipe and must not inject a bubble.
  always_comb begin
    hz.stop_F  = 1'b0;
    hz.stop_D  = 1'b0;
    hz.stop_E  = 1'b0;
    hz.stop_M  = 1'b0;
    hz.flush_E = 1'b0;
    hz.mem_req = mem_stall;
    hz.md_busy = md_busy_c;
    if (mem_stall) begin
      hz.stop_F = 1'b1;
      hz.stop_D = 1'b1;
      hz.stop_E = 1'b1;
      hz.stop_M = 1'b1;
    end else if (load_use || hilo_stall) begin
      hz.stop_F  = 1'b1;
      hz.stop_D  = 1'b1;
      hz.flush_E = 1'b1;
    end
  end

  // Next state: memory wait tracking and the mult/div busy countdown run independently.
  always_comb begin
    mem_state_d = mem_state_q;
    md_cnt_d    = md_cnt_q;
    unique case (mem_state_q)
      IDLE:     if (mem_acc_m && !hz.mem_ack) mem_state_d = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ack) mem_state_d = IDLE;
      default:  mem_state_d = IDLE;
    endcase
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end else if (is_md(op_e, fn_e) && !hz.stop_E) begin
      md_cnt_d = (fn_e[1] == 1'b0) ? MD_W'(MUL_CYC) : MD_W'(DIV_CYC);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_state_q <= IDLE;
      md_cnt_q    <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      md_cnt_q    <= md_cnt_d;
    end
  end
endmodule
